// File: rtl/spi_master.sv
// 16-bit SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A word is requested with START and reported with a one-cycle RDY pulse.
// Holding START on the word-end cycle chains another word under the same
// SS-low frame, so 32/48-bit commands go out without an SS gap.
module spi_master #(
  parameter int HALF_PERIOD = 4,  // CLK cycles per SCK half-period (>= 3)
  parameter int CS_SETUP    = 4,  // SS fall to first SCK rise (>= 1)
  parameter int CS_HOLD     = 4,  // last SCK fall to SS rise (>= 1)
  parameter int CS_IDLE     = 4   // SS high time before BUSY drops (>= 1)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [15:0] TX,
  output logic        BUSY,
  output logic [15:0] RX,
  output logic        RDY,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  // Phase counter must hold the longest of the four timing parameters.
  localparam int MAX_A   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LD_HALF  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] LD_IDLE  = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t        state_r,  state_s;
  logic [CW-1:0] cnt_r,    cnt_s;
  logic [3:0]    bitcnt_r, bitcnt_s;
  logic          chain_r,  chain_s;
  logic [15:0]   tx_sh_r,  tx_sh_s;
  logic [15:0]   rx_sh_r,  rx_sh_s;
  logic [15:0]   rx_r,     rx_s;
  logic          rdy_r,    rdy_s;
  logic          sck_r,    sck_s;
  logic          mosi_r,   mosi_s;
  logic          ss_r,     ss_s;
  logic          busy_r,   busy_s;

  logic          miso_meta_r;
  logic          miso_s_r;
  logic [15:0]   rx_word_s;

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      miso_meta_r <= 1'b0;
      miso_s_r    <= 1'b0;
    end else begin
      miso_meta_r <= MISO;
      miso_s_r    <= miso_meta_r;
    end
  end

  // Word as it stands once the bit sampled on this falling edge is shifted in.
  assign rx_word_s = {rx_sh_r[14:0], miso_s_r};

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bitcnt_s = bitcnt_r;
    chain_s  = chain_r;
    tx_sh_s  = tx_sh_r;
    rx_sh_s  = rx_sh_r;
    rx_s     = rx_r;
    rdy_s    = 1'b0;
    sck_s    = sck_r;
    mosi_s   = mosi_r;
    ss_s     = ss_r;
    busy_s   = busy_r;

    case (state_r)
      ST_IDLE: begin
        sck_s  = 1'b0;
        if (START) begin
          tx_sh_s  = TX;
          bitcnt_s = 4'd0;
          chain_s  = 1'b0;
          ss_s     = 1'b0;
          busy_s   = 1'b1;
          mosi_s   = TX[15];
          cnt_s    = LD_SETUP;
          state_s  = ST_SETUP;
        end else begin
          ss_s   = 1'b1;
          mosi_s = 1'b0;
          busy_s = 1'b0;
        end
      end

      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          sck_s   = 1'b1;
          cnt_s   = LD_HALF;
          state_s = ST_HIGH;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_HIGH: begin
        if (cnt_r == CNT_ZERO) begin
          // Sample late in the high phase; the slave moves MISO only after the fall.
          sck_s   = 1'b0;
          rx_sh_s = rx_word_s;
          if (bitcnt_r == 4'd15) begin
            rx_s  = rx_word_s;
            rdy_s = 1'b1;
            if (START) begin
              tx_sh_s  = TX;
              bitcnt_s = 4'd0;
              chain_s  = 1'b1;
              mosi_s   = TX[15];
              cnt_s    = LD_HALF;
              state_s  = ST_LOW;
            end else begin
              mosi_s  = 1'b0;
              cnt_s   = LD_HOLD;
              state_s = ST_HOLD;
            end
          end else begin
            tx_sh_s = {tx_sh_r[14:0], 1'b0};
            mosi_s  = tx_sh_r[14];
            cnt_s   = LD_HALF;
            state_s = ST_LOW;
          end
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_LOW: begin
        if (cnt_r == CNT_ZERO) begin
          // A chained word starts again at bit 0 instead of advancing.
          sck_s = 1'b1;
          if (chain_r) begin
            bitcnt_s = 4'd0;
          end else begin
            bitcnt_s = bitcnt_r + 4'd1;
          end
          chain_s = 1'b0;
          cnt_s   = LD_HALF;
          state_s = ST_HIGH;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          ss_s    = 1'b1;
          cnt_s   = LD_IDLE;
          state_s = ST_GAP;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        // Unreachable encodings fall back to a quiet, deselected bus.
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        sck_s   = 1'b0;
        mosi_s  = 1'b0;
        ss_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word and deselects the slave.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      bitcnt_r <= 4'd0;
      chain_r  <= 1'b0;
      tx_sh_r  <= 16'h0000;
      rx_sh_r  <= 16'h0000;
      rx_r     <= 16'h0000;
      rdy_r    <= 1'b0;
      sck_r    <= 1'b0;
      mosi_r   <= 1'b0;
      ss_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bitcnt_r <= bitcnt_s;
      chain_r  <= chain_s;
      tx_sh_r  <= tx_sh_s;
      rx_sh_r  <= rx_sh_s;
      rx_r     <= rx_s;
      rdy_r    <= rdy_s;
      sck_r    <= sck_s;
      mosi_r   <= mosi_s;
      ss_r     <= ss_s;
      busy_r   <= busy_s;
    end
  end

  assign BUSY = busy_r;
  assign RX   = rx_r;
  assign RDY  = rdy_r;
  assign SCK  = sck_r;
  assign MOSI = mosi_r;
  assign SS   = ss_r;

endmodule
